// File: rtl/mul_pipe_regs_pkg.sv
// rtl/mul_pipe_regs_pkg.sv - shared types and width defaults for the multiply pipeline registers
package mul_pipe_regs_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REGW_DEF = 5;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef struct packed {
    logic                    valid;
    logic [REGW_DEF-1:0]     rd;
    mul_op_t                 op;
    logic [XLEN_DEF-1:0]     a;
    logic [XLEN_DEF-1:0]     b;
    logic [2*XLEN_DEF-1:0]   prod;
  } mul_slot_t;

endpackage

// File: rtl/mul_pipe_regs_if.sv
// rtl/mul_pipe_regs_if.sv - ID/EX/MEM/WB multiply pipeline bus between decode, multiplier stages and the slot registers
interface mul_pipe_regs_if
  import mul_pipe_regs_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int REGW = REGW_DEF
) ();

  logic                STALL;
  logic                FLUSH;
  logic                ISSUE_VALID;
  logic [1:0]          MUL_OP_IN;
  logic [REGW-1:0]     RD_IN;
  logic [XLEN-1:0]     A_IN;
  logic [XLEN-1:0]     B_IN;
  logic [REGW-1:0]     RS1_ID;
  logic [REGW-1:0]     RS2_ID;
  logic [XLEN-1:0]     E_AOUT;
  logic [XLEN-1:0]     E_BOUT;
  logic [2*XLEN-1:0]   E_POUT;
  logic [XLEN-1:0]     M_OUT;
  logic [XLEN-1:0]     A_EX;
  logic [XLEN-1:0]     B_EX;
  logic [1:0]          MUL_OP_E;
  logic [XLEN-1:0]     A_MEM;
  logic [XLEN-1:0]     B_MEM;
  logic [2*XLEN-1:0]   E_PIN;
  logic [XLEN-1:0]     A_WB;
  logic [XLEN-1:0]     B_WB;
  logic [1:0]          MUL_OP_W;
  logic [2*XLEN-1:0]   W_PIN;
  logic                WB_VALID;
  logic [REGW-1:0]     WB_RD;
  logic                HAZARD;

  modport master (
    output STALL, FLUSH, ISSUE_VALID, MUL_OP_IN, RD_IN, A_IN, B_IN, RS1_ID, RS2_ID,
           E_AOUT, E_BOUT, E_POUT, M_OUT,
    input  A_EX, B_EX, MUL_OP_E, A_MEM, B_MEM, E_PIN, A_WB, B_WB, MUL_OP_W, W_PIN,
           WB_VALID, WB_RD, HAZARD
  );

  modport slave (
    input  STALL, FLUSH, ISSUE_VALID, MUL_OP_IN, RD_IN, A_IN, B_IN, RS1_ID, RS2_ID,
           E_AOUT, E_BOUT, E_POUT, M_OUT,
    output A_EX, B_EX, MUL_OP_E, A_MEM, B_MEM, E_PIN, A_WB, B_WB, MUL_OP_W, W_PIN,
           WB_VALID, WB_RD, HAZARD
  );

endinterface

// File: rtl/mul_slot_reg.sv
// rtl/mul_slot_reg.sv - one pipeline slot register with reset, bubble (zero-load) and hold
module mul_slot_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Bubble beats hold so a flush can kill a slot during a global stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (bubble) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mul_pipe_regs.sv
// rtl/mul_pipe_regs.sv - EX/MEM/WB slot registers and decode hazard for the 3-stage multiplier
// Optional feature: define MUL_HAZARD_EN to enable the rd/rs dependency check; otherwise HAZARD is 0.
module mul_pipe_regs
  import mul_pipe_regs_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int REGW = REGW_DEF
) (
  input logic           CLK,
  input logic           RST,
  mul_pipe_regs_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [REGW-1:0]   rd;
    mul_op_t           op;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
  } ex_slot_t;

  // EX never carries a product; MEM/WB append one to the EX fields.
  typedef struct packed {
    ex_slot_t          core;
    logic [2*XLEN-1:0] prod;
  } slot_t;

  ex_slot_t ex_d, ex_q;
  slot_t    mem_d, mem_q;
  slot_t    wb_d, wb_q;
  logic     ex_bubble, mem_bubble, wb_bubble;

  always_comb begin
    ex_d.valid = 1'b1;
    ex_d.rd    = bus.RD_IN;
    ex_d.op    = mul_op_t'(bus.MUL_OP_IN);
    ex_d.a     = bus.A_IN;
    ex_d.b     = bus.B_IN;

    mem_d.core   = ex_q;
    mem_d.core.a = bus.E_AOUT;
    mem_d.core.b = bus.E_BOUT;
    mem_d.prod   = bus.E_POUT;

    wb_d.core = mem_q.core;
    wb_d.prod = {mem_q.prod[2*XLEN-1:XLEN], bus.M_OUT};
  end

  assign ex_bubble  = bus.FLUSH | (~bus.STALL & ~bus.ISSUE_VALID);
  assign mem_bubble = ~bus.STALL & ~ex_q.valid;
  assign wb_bubble  = ~bus.STALL & ~mem_q.core.valid;

  mul_slot_reg #(.W($bits(ex_slot_t))) u_ex (
    .clk(CLK), .rst(RST), .hold(bus.STALL), .bubble(ex_bubble), .d(ex_d), .q(ex_q)
  );

  mul_slot_reg #(.W($bits(slot_t))) u_mem (
    .clk(CLK), .rst(RST), .hold(bus.STALL), .bubble(mem_bubble), .d(mem_d), .q(mem_q)
  );

  mul_slot_reg #(.W($bits(slot_t))) u_wb (
    .clk(CLK), .rst(RST), .hold(bus.STALL), .bubble(wb_bubble), .d(wb_d), .q(wb_q)
  );

  assign bus.A_EX     = ex_q.a;
  assign bus.B_EX     = ex_q.b;
  assign bus.MUL_OP_E = ex_q.op;
  assign bus.A_MEM    = mem_q.core.a;
  assign bus.B_MEM    = mem_q.core.b;
  assign bus.E_PIN    = mem_q.prod;
  assign bus.A_WB     = wb_q.core.a;
  assign bus.B_WB     = wb_q.core.b;
  assign bus.MUL_OP_W = wb_q.core.op;
  assign bus.W_PIN    = wb_q.prod;
  assign bus.WB_VALID = wb_q.core.valid;
  assign bus.WB_RD    = wb_q.core.rd;

`ifdef MUL_HAZARD_EN
  // WB is excluded: its result is forwarded to decode.
  function automatic logic rd_hit(input ex_slot_t s, input logic [REGW-1:0] rs1,
                                  input logic [REGW-1:0] rs2);
    return s.valid && (s.rd != '0) && ((s.rd == rs1) || (s.rd == rs2));
  endfunction

  assign bus.HAZARD = rd_hit(ex_q, bus.RS1_ID, bus.RS2_ID)
                    | rd_hit(mem_q.core, bus.RS1_ID, bus.RS2_ID);
`else
  logic unused_rs;
  assign unused_rs  = ^{bus.RS1_ID, bus.RS2_ID};
  assign bus.HAZARD = 1'b0;
`endif

endmodule
